// File: rtl/kianv_seq_multiplier_pkg.sv
// Shared definitions for the sequential multiplier.
// Also carries the riscv_defines operation encodings (MUL_OP_* and DIV_OP_*)
// so every file compiled after this one sees the same values.
// Optional feature macro: MUL_EARLY_EXIT_EN (see kianv_seq_multiplier.sv).
`ifndef RISCV_DEFINES_VH
`define RISCV_DEFINES_VH
`define MUL_OP_WIDTH     2
`define MUL_OP_MUL       2'b00
`define MUL_OP_MULH      2'b01
`define MUL_OP_MULHSU    2'b10
`define MUL_OP_MULHU     2'b11
`define DIV_OP_WIDTH     2
`define DIV_OP_DIV       2'b00
`define DIV_OP_DIVU      2'b01
`define DIV_OP_REM       2'b10
`define DIV_OP_REMU      2'b11
`endif

package kianv_seq_multiplier_pkg;

    localparam int MUL_OP_W = `MUL_OP_WIDTH;

    localparam logic [MUL_OP_W-1:0] MUL_OP_MUL    = `MUL_OP_MUL;
    localparam logic [MUL_OP_W-1:0] MUL_OP_MULH   = `MUL_OP_MULH;
    localparam logic [MUL_OP_W-1:0] MUL_OP_MULHSU = `MUL_OP_MULHSU;
    localparam logic [MUL_OP_W-1:0] MUL_OP_MULHU  = `MUL_OP_MULHU;

endpackage

// File: rtl/kianv_seq_multiplier.sv
// Radix-2 shift-add sequential multiplier for RV32M MUL/MULH/MULHSU/MULHU.
// Operands are made non-negative on accept, multiplied unsigned over 32
// steps, and the 64-bit product is negated at the end if the signs differ.
// Optional: define MUL_EARLY_EXIT_EN to leave the step loop as soon as the
// remaining multiplier is zero (latency 3 + msb index of |factor2|).
module kianv_seq_multiplier
    import kianv_seq_multiplier_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [XLEN-1:0]          factor1,
    input  logic [XLEN-1:0]          factor2,
    input  logic [`MUL_OP_WIDTH-1:0] MULop,
    input  logic                     valid,
    output logic                     ready,
    output logic [XLEN-1:0]          mulRslt
);

    // One-hot state bit positions
    localparam int S_IDLE  = 0;
    localparam int S_CALC  = 1;
    localparam int S_READY = 2;

    localparam logic [2:0] ST_IDLE  = 3'b001;
    localparam logic [2:0] ST_CALC  = 3'b010;
    localparam logic [2:0] ST_READY = 3'b100;

    logic [2:0]        state_q, state_d;
    logic              ready_q, ready_d;
    logic [2*XLEN-1:0] product_q, product_d;
    logic [2*XLEN-1:0] mcand_q, mcand_d;
    logic [XLEN-1:0]   mplier_q, mplier_d;
    logic [4:0]        cnt_q, cnt_d;

    logic              f1_signed, f2_signed;
    logic              f1_neg, f2_neg;
    logic [XLEN-1:0]   f1_abs, f2_abs;
    logic              last_step;

    // Operand signedness and magnitude; 0x80000000 negates to itself,
    // which is the correct unsigned magnitude.
    always_comb begin
        f1_signed = (MULop == MUL_OP_MULH) || (MULop == MUL_OP_MULHSU);
        f2_signed = (MULop == MUL_OP_MULH);
        f1_neg    = f1_signed && factor1[XLEN-1];
        f2_neg    = f2_signed && factor2[XLEN-1];
        f1_abs    = f1_neg ? (~factor1 + 1'b1) : factor1;
        f2_abs    = f2_neg ? (~factor2 + 1'b1) : factor2;
    end

    // Decide whether the current CALC step is the final one
    always_comb begin
`ifdef MUL_EARLY_EXIT_EN
        last_step = (cnt_q == 5'd31) || ((mplier_q >> 1) == '0);
`else
        last_step = (cnt_q == 5'd31);
`endif
    end

    // State register plus reset-controlled flops
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            ready_q   <= 1'b0;
            product_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            ready_q   <= ready_d;
            product_q <= product_d;
            cnt_q     <= cnt_d;
        end
    end

    // Operand shift registers need no reset; they are loaded on accept
    always_ff @(posedge clk) begin
        mcand_q  <= mcand_d;
        mplier_q <= mplier_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (1'b1)
            state_q[S_IDLE]:  if (valid && !ready_q) state_d = ST_CALC;
            state_q[S_CALC]:  if (last_step) state_d = ST_READY;
            state_q[S_READY]: state_d = ST_IDLE;
            default:          state_d = ST_IDLE;
        endcase
    end

    // Datapath and ready generation per state
    always_comb begin
        ready_d   = 1'b0;
        product_d = product_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        cnt_d     = cnt_q;
        unique case (1'b1)
            state_q[S_IDLE]: begin
                if (valid && !ready_q) begin
                    mcand_d   = {{XLEN{1'b0}}, f1_abs};
                    mplier_d  = f2_abs;
                    product_d = '0;
                    cnt_d     = '0;
                end
            end
            state_q[S_CALC]: begin
                if (mplier_q[0]) product_d = product_q + mcand_q;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 5'd1;
            end
            state_q[S_READY]: begin
                if (f1_neg ^ f2_neg) product_d = ~product_q + 1'b1;
                ready_d = 1'b1;
            end
            default: ;
        endcase
    end

    assign ready   = ready_q;
    assign mulRslt = (MULop == MUL_OP_MUL) ? product_q[XLEN-1:0]
                                           : product_q[2*XLEN-1:XLEN];

endmodule

// File: tb/tb_kianv_seq_multiplier.sv
// Self-checking bench for kianv_seq_multiplier with an expected-result queue.
// Build with MUL_EARLY_EXIT_EN defined to exercise the early-exit latency.
module tb_kianv_seq_multiplier;
    import kianv_seq_multiplier_pkg::*;

    logic                clk = 1'b0;
    logic                resetn = 1'b0;
    logic [31:0]         factor1 = '0;
    logic [31:0]         factor2 = '0;
    logic [MUL_OP_W-1:0] mul_op = MUL_OP_MUL;
    logic                valid = 1'b0;
    logic                ready;
    logic [31:0]         mul_rslt;

    kianv_seq_multiplier #(.XLEN(32)) dut (
        .clk     (clk),
        .resetn  (resetn),
        .factor1 (factor1),
        .factor2 (factor2),
        .MULop   (mul_op),
        .valid   (valid),
        .ready   (ready),
        .mulRslt (mul_rslt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        int          lat;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_res(input logic [MUL_OP_W-1:0] op,
                                              input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea, eb, p;
        ea = {{32{(op == MUL_OP_MULH || op == MUL_OP_MULHSU) && a[31]}}, a};
        eb = {{32{(op == MUL_OP_MULH) && b[31]}}, b};
        p  = ea * eb;
        return (op == MUL_OP_MUL) ? p[31:0] : p[63:32];
    endfunction

    function automatic int model_lat(input logic [MUL_OP_W-1:0] op, input logic [31:0] b);
        int lat;
        logic [31:0] mag;
        mag = (op == MUL_OP_MULH && b[31]) ? (32'd0 - b) : b;
        lat = 34;
`ifdef MUL_EARLY_EXIT_EN
        lat = 3;
        for (int i = 0; i < 32; i++) if (mag[i]) lat = 3 + i;
`else
        if (mag == 32'hFFFF_FFFF) lat = 34;
`endif
        return lat;
    endfunction

    // Monitor: track the accepting edge and score each ready pulse
    int cyc = 0;
    int acc_cyc = 0;
    int done_cnt = 0;
    bit busy = 1'b0;
    bit prev_rdy = 1'b0;

    always @(posedge clk) begin
        exp_t e;
        cyc++;
        if (!resetn) busy = 1'b0;
        else if (!busy && valid && !ready) begin
            busy    = 1'b1;
            acc_cyc = cyc;
        end
        #1;
        if (prev_rdy) chk("ready_width", {63'd0, ready}, 64'd0);
        if (ready) begin
            if (sb.size() == 0) chk("unexpected_ready", 64'd1, 64'd0);
            else begin
                e = sb.pop_front();
                chk({e.tag, "_res"}, {32'd0, mul_rslt}, {32'd0, e.res});
                chk({e.tag, "_lat"}, 64'(cyc - acc_cyc + 1), 64'(e.lat));
            end
            busy = 1'b0;
            done_cnt++;
        end
        prev_rdy = ready;
    end

    task automatic set_ops(input logic [MUL_OP_W-1:0] op, input logic [31:0] a,
                           input logic [31:0] b, input string tag);
        mul_op  = op;
        factor1 = a;
        factor2 = b;
        valid   = 1'b1;
        sb.push_back('{model_res(op, a, b), model_lat(op, b), tag});
    endtask

    task automatic wait_done(input int target);
        int n = 0;
        while (done_cnt < target && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (done_cnt < target) chk("timeout", 64'(done_cnt), 64'(target));
    endtask

    task automatic run_op(input logic [MUL_OP_W-1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input string tag);
        @(negedge clk);
        set_ops(op, a, b, tag);
        wait_done(done_cnt + 1);
        valid = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ready", {63'd0, ready}, 64'd0);
        chk("rst_rslt", {32'd0, mul_rslt}, 64'd0);
        chk("rst_state", {61'd0, dut.state_q}, 64'd1);
        resetn = 1'b1;
        @(negedge clk);

        // Directed vectors
        run_op(MUL_OP_MUL,    32'h0000_0007, 32'h0000_0006, "mul_7x6");
        run_op(MUL_OP_MULH,   32'h8000_0000, 32'h8000_0000, "mulh_min");
        run_op(MUL_OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu_max");
        run_op(MUL_OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_m1");
        run_op(MUL_OP_MULH,   32'hFFFF_FFFF, 32'h0000_0002, "mulh_m1x2");
        run_op(MUL_OP_MUL,    32'hFFFF_FFFF, 32'h0000_0002, "mul_m1x2");
        run_op(MUL_OP_MULHU,  32'h1234_5678, 32'h0000_0001, "mulhu_x1");
        run_op(MUL_OP_MUL,    32'h0000_0000, 32'h0000_0005, "mul_zero_a");
        run_op(MUL_OP_MULH,   32'h7FFF_FFFF, 32'h0000_0000, "mulh_zero_b");
        run_op(MUL_OP_MULH,   32'h0001_0000, 32'hFFFF_0000, "mulh_neg_b");

        // Random vectors across all operations
        for (int i = 0; i < 6; i++)
            run_op(MUL_OP_W'(i % 4), $urandom, $urandom, $sformatf("rand%0d", i));

        // valid held high across two back-to-back requests
        @(negedge clk);
        set_ops(MUL_OP_MULHU, 32'hDEAD_BEEF, 32'h0000_F00D, "b2b_first");
        wait_done(done_cnt + 1);
        set_ops(MUL_OP_MULH, 32'h8000_0001, 32'h0000_0003, "b2b_second");
        wait_done(done_cnt + 1);
        valid = 1'b0;

        // Reset mid-CALC aborts the operation without a ready pulse
        @(negedge clk);
        set_ops(MUL_OP_MUL, 32'h0000_1234, 32'hF000_5678, "aborted");
        repeat (11) @(negedge clk);
        resetn = 1'b0;
        valid  = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        void'(sb.pop_back());
        mul_op = MUL_OP_MUL;
        #1;
        chk("abort_state", {61'd0, dut.state_q}, 64'd1);
        chk("abort_rslt", {32'd0, mul_rslt}, 64'd0);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ready) chk("abort_ready", {63'd0, ready}, 64'd0);
        end
        chk("abort_no_pulse", 64'(done_cnt), 64'(done_cnt));
        run_op(MUL_OP_MULH, 32'hFFFF_FFF9, 32'h0000_0006, "after_abort");

        repeat (3) @(negedge clk);
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
